// File: rtl/irq_vector_ctrl.sv
// Eight-input vectored interrupt controller on the CPU I/O bus: prioritises irqn, drives intn, answers INTA.
// Define IRQ_EDGE_EN for edge-latched requests; the default build uses level-sensitive requests.
module irq_vector_ctrl #(
   parameter logic [7:0]  IO_ADDR = 8'h18,
   parameter int unsigned NIRQ    = 8
) (
   input  logic             gclk1,
   input  logic             resetn,
   input  logic [NIRQ-1:0]  irqn,
   input  logic [15:0]      A,
   input  logic [7:0]       d_in,
   input  logic             iorqn,
   input  logic             intan,
   input  logic             rdn,
   input  logic             wrn,
   output logic             intn,
   output logic [7:0]       d_out,
   output logic             d_oe
);

   localparam int unsigned IDW = 3;
   localparam int unsigned VBW = 5;
   localparam int unsigned DW  = 8;

   typedef enum logic [1:0] {IDLE, REQ, ACK, SERV} state_t;

   state_t            state_q, state_d;
   logic [NIRQ-1:0]   irq_m, irq_s;
   logic [3:0]        ctl_m, ctl_s;
   logic              wr_q;
   logic              iorq_s, intan_s, rd_s, wr_s;
   logic [NIRQ-1:0]   mask_q, pend, req;
   logic [VBW-1:0]    vbase_q;
   logic [IDW-1:0]    id_q, win_id;
   logic [DW-1:0]     vec_q, vec_c, rd_data;
   logic [7:0]        offs;
   logic              sel, io_cyc, rd_act, wr_stb, wr_mask, wr_pend, wr_eoi;
   logic              latch;
   logic              intn_d, d_oe_d;
   logic [DW-1:0]     d_out_d;
   logic              unused_bits;

   assign unused_bits = ^{A[15:8], d_in[2:0]};

   // Two-flop synchronisers for every bus input sampled as a strobe or request
   always_ff @(posedge gclk1 or negedge resetn) begin
      if (!resetn) begin
         irq_m <= '1;
         irq_s <= '1;
         ctl_m <= '1;
         ctl_s <= '1;
         wr_q  <= 1'b1;
      end else begin
         irq_m <= irqn;
         irq_s <= irq_m;
         ctl_m <= {iorqn, intan, rdn, wrn};
         ctl_s <= ctl_m;
         wr_q  <= ctl_s[0];
      end
   end

   assign iorq_s  = ctl_s[3];
   assign intan_s = ctl_s[2];
   assign rd_s    = ctl_s[1];
   assign wr_s    = ctl_s[0];

   // Address offset wraps for A below IO_ADDR, so one compare covers the range
   assign offs    = A[7:0] - IO_ADDR;
   assign sel     = (offs < 8'd3);
   assign io_cyc  = !iorq_s && intan_s && sel && (state_q != ACK);
   assign rd_act  = io_cyc && !rd_s;
   assign wr_stb  = io_cyc && !wr_s && wr_q;
   assign wr_mask = wr_stb && (offs[1:0] == 2'd0);
   assign wr_pend = wr_stb && (offs[1:0] == 2'd1);
   assign wr_eoi  = wr_stb && (offs[1:0] == 2'd2);

`ifdef IRQ_EDGE_EN
   logic [NIRQ-1:0] irq_q, pend_q, fall, clr;

   assign fall = irq_q & ~irq_s;
   assign clr  = (latch ? (NIRQ'(1) << win_id) : '0) | (wr_pend ? d_in : '0);
   assign pend = pend_q;

   // Edge-latched pending bits; a repeated edge on a pending line merges into it
   always_ff @(posedge gclk1 or negedge resetn) begin
      if (!resetn) begin
         irq_q  <= '1;
         pend_q <= '0;
      end else begin
         irq_q  <= irq_s;
         pend_q <= (pend_q & ~clr) | fall;
      end
   end
`else
   assign pend = ~irq_s;
`endif

   assign req = pend & mask_q;

   // Lowest set bit wins
   always_comb begin
      win_id = '0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (req[i]) win_id = IDW'(i);
      end
   end

   assign vec_c = {vbase_q, win_id};

   always_comb begin
      rd_data = '0;
      case (offs[1:0])
         2'd0:    rd_data = mask_q;
         2'd1:    rd_data = pend;
         2'd2:    rd_data = {state_q == SERV, 4'b0000, id_q};
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge gclk1 or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state plus registered-output targets
   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      d_oe_d  = 1'b0;
      d_out_d = '0;
      case (state_q)
         IDLE: if (req != '0) state_d = REQ;
         REQ: begin
            if (req == '0) begin
               state_d = IDLE;
            end else if (!iorq_s && !intan_s) begin
               state_d = ACK;
               latch   = 1'b1;
            end
         end
         ACK:  if (intan_s) state_d = SERV;
         SERV: if (wr_eoi) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      intn_d = !((state_d == REQ) || (state_d == ACK));
      if (state_d == ACK) begin
         d_oe_d  = 1'b1;
         d_out_d = latch ? vec_c : vec_q;
      end else if (rd_act) begin
         d_oe_d  = 1'b1;
         d_out_d = rd_data;
      end
   end

   always_ff @(posedge gclk1 or negedge resetn) begin
      if (!resetn) begin
         mask_q  <= '0;
         vbase_q <= '0;
         id_q    <= '0;
         vec_q   <= '0;
         intn    <= 1'b1;
         d_oe    <= 1'b0;
         d_out   <= '0;
      end else begin
         if (wr_mask) mask_q  <= d_in;
         if (wr_pend) vbase_q <= d_in[7:3];
         if (latch) begin
            id_q  <= win_id;
            vec_q <= vec_c;
         end
         intn  <= intn_d;
         d_oe  <= d_oe_d;
         d_out <= d_out_d;
      end
   end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl: bus read/write/INTA sequences with hand-computed expectations.
module tb_irq_vector_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  irqn;
   logic [15:0] A;
   logic [7:0]  d_in;
   logic        iorqn, intan, rdn, wrn;
   logic        intn;
   logic [7:0]  d_out;
   logic        d_oe;

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] rd;
   logic       oe;

   irq_vector_ctrl dut (
      .gclk1  (clk),
      .resetn (resetn),
      .irqn   (irqn),
      .A      (A),
      .d_in   (d_in),
      .iorqn  (iorqn),
      .intan  (intan),
      .rdn    (rdn),
      .wrn    (wrn),
      .intn   (intn),
      .d_out  (d_out),
      .d_oe   (d_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
      A = {8'h00, addr};
      d_in = data;
      iorqn = 1'b0;
      wrn = 1'b0;
      tick(4);
      wrn = 1'b1;
      iorqn = 1'b1;
      tick(4);
   endtask

   task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic en);
      A = {8'h00, addr};
      iorqn = 1'b0;
      rdn = 1'b0;
      tick(4);
      data = d_out;
      en = d_oe;
      rdn = 1'b1;
      iorqn = 1'b1;
      tick(4);
   endtask

   initial begin
      resetn = 1'b0;
      irqn = 8'hFF;
      A = '0;
      d_in = '0;
      iorqn = 1'b1;
      intan = 1'b1;
      rdn = 1'b1;
      wrn = 1'b1;
      tick(3);
      resetn = 1'b1;
      tick(1);
      chk("reset_intn", 8'(intn), 8'h01);
      chk("reset_d_oe", 8'(d_oe), 8'h00);
      chk("reset_d_out", d_out, 8'h00);

`ifndef IRQ_EDGE_EN
      // Test 1: masked request raises no interrupt but shows in PEND
      irqn = 8'hFE;
      tick(6);
      chk("t1_intn", 8'(intn), 8'h01);
      io_read(8'h19, rd, oe);
      chk("t1_pend_oe", 8'(oe), 8'h01);
      chk("t1_pend", rd, 8'h01);
      chk("t1_oe_released", 8'(d_oe), 8'h00);
      io_read(8'h18, rd, oe);
      chk("t1_mask", rd, 8'h00);

      // Test 2: two requests, id 1 wins, INTA returns {VBASE,1}
      irqn = 8'hFF;
      io_write(8'h19, 8'hA0);
      io_write(8'h18, 8'hFF);
      irqn = 8'hF5;
      tick(2);
      chk("t2_intn_early", 8'(intn), 8'h01);
      tick(1);
      chk("t2_intn_low", 8'(intn), 8'h00);
      iorqn = 1'b0;
      intan = 1'b0;
      tick(2);
      chk("t2_oe_early", 8'(d_oe), 8'h00);
      tick(1);
      chk("t2_ack_oe", 8'(d_oe), 8'h01);
      chk("t2_vector", d_out, 8'hA1);
      chk("t2_ack_intn", 8'(intn), 8'h00);
      intan = 1'b1;
      iorqn = 1'b1;
      tick(3);
      chk("t2_serv_oe", 8'(d_oe), 8'h00);
      chk("t2_serv_intn", 8'(intn), 8'h01);
      io_read(8'h1A, rd, oe);
      chk("t2_status", rd, 8'h81);

      // Test 3: EOI with irq1 still low re-requests; release during ACK keeps the latched vector
      io_write(8'h1A, 8'h00);
      chk("t3_intn_again", 8'(intn), 8'h00);
      iorqn = 1'b0;
      intan = 1'b0;
      tick(3);
      chk("t3_vector_id1", d_out, 8'hA1);
      irqn = 8'hF7;
      tick(4);
      chk("t3_released_vec", d_out, 8'hA1);
      chk("t3_released_oe", 8'(d_oe), 8'h01);
      intan = 1'b1;
      iorqn = 1'b1;
      tick(3);
      io_write(8'h1A, 8'h00);
      chk("t3_intn_irq3", 8'(intn), 8'h00);
      iorqn = 1'b0;
      intan = 1'b0;
      tick(3);
      chk("t3_vector_id3", d_out, 8'hA3);
      intan = 1'b1;
      iorqn = 1'b1;
      irqn = 8'hFF;
      tick(3);
      io_write(8'h1A, 8'h00);
      chk("t3_idle_intn", 8'(intn), 8'h01);
      io_write(8'h1A, 8'h00);
      io_read(8'h1A, rd, oe);
      chk("t3_eoi_idle_status", rd, 8'h03);

      // Test 4: masking the pending request withdraws intn
      irqn = 8'hFB;
      tick(4);
      chk("t4_intn_low", 8'(intn), 8'h00);
      io_write(8'h18, 8'h00);
      chk("t4_intn_withdrawn", 8'(intn), 8'h01);
      io_read(8'h1A, rd, oe);
      chk("t4_status", rd, 8'h03);

      // Test 5: reset during ACK drops d_oe and intn at once
      io_write(8'h18, 8'hFF);
      tick(1);
      iorqn = 1'b0;
      intan = 1'b0;
      tick(3);
      chk("t5_ack_oe", 8'(d_oe), 8'h01);
      chk("t5_vector", d_out, 8'hA2);
      #2 resetn = 1'b0;
      #1;
      chk("t5_rst_oe", 8'(d_oe), 8'h00);
      chk("t5_rst_intn", 8'(intn), 8'h01);
      intan = 1'b1;
      iorqn = 1'b1;
      irqn = 8'hFF;
      tick(2);
      resetn = 1'b1;
      tick(2);
      io_read(8'h18, rd, oe);
      chk("t5_mask", rd, 8'h00);
      io_read(8'h19, rd, oe);
      chk("t5_pend", rd, 8'h00);
`else
      // Test 6: a short pulse on irq5n is latched and cleared by the acknowledge
      io_write(8'h19, 8'hA0);
      io_write(8'h18, 8'h20);
      irqn = 8'hDF;
      tick(4);
      irqn = 8'hFF;
      tick(4);
      chk("t6_intn_low", 8'(intn), 8'h00);
      io_read(8'h19, rd, oe);
      chk("t6_pend_latched", rd, 8'h20);
      iorqn = 1'b0;
      intan = 1'b0;
      tick(3);
      chk("t6_ack_oe", 8'(d_oe), 8'h01);
      chk("t6_vector", d_out, 8'hA5);
      intan = 1'b1;
      iorqn = 1'b1;
      tick(3);
      chk("t6_serv_oe", 8'(d_oe), 8'h00);
      chk("t6_serv_intn", 8'(intn), 8'h01);
      io_read(8'h19, rd, oe);
      chk("t6_pend_cleared", rd, 8'h00);
      io_read(8'h1A, rd, oe);
      chk("t6_status", rd, 8'h85);
      io_write(8'h1A, 8'h00);
      chk("t6_eoi_intn", 8'(intn), 8'h01);
      irqn = 8'h7F;
      tick(4);
      irqn = 8'hFF;
      tick(4);
      io_read(8'h19, rd, oe);
      chk("t6_pend_irq7", rd, 8'h80);
      chk("t6_masked_intn", 8'(intn), 8'h01);
      io_write(8'h19, 8'h80);
      io_read(8'h19, rd, oe);
      chk("t6_pend_wr_clear", rd, 8'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
